play_scheduler: RTL
===================

# play_scheduler

Sequencing controller for the two-source VGA/audio output mux. Debounces the front-panel play/next/stop keys and drives the mux's `EN`, `sakura` and `badapple` controls. Enforces a blanked, muted gap between tracks and auto-advances or loops when a player reports end-of-track. Also issues a one-cycle restart pulse to the selected player so that picture and music start from the top together.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required to accept a key press (10 ms at 25 MHz).
- `GAP_CYCLES`, default 12500000: length of the blanked gap between tracks (0.5 s); must be ≥ 2.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_play`  in  1  raw key, asynchronous, active high.
- `btn_next`  in  1  raw key, asynchronous, active high.
- `btn_stop`  in  1  raw key, asynchronous, active high.
- `loop_mode`  in  1  level, synchronous to `clk`; 1 replays the same track on end, 0 advances.
- `done1`  in  1  one-cycle end-of-track pulse from source 1 (sakura player).
- `done2`  in  1  one-cycle end-of-track pulse from source 2 (badapple player).
- `EN`  out  1  mux blank/mute; 1 forces black video and silent speaker.
- `sakura`  out  1  selects source 1.
- `badapple`  out  1  selects source 2.
- `start1`  out  1  one-cycle restart pulse to source 1.
- `start2`  out  1  one-cycle restart pulse to source 2.
- `playing`  out  1  high in PLAY only.

## Operation
- **Key debounce.** Each key goes through a 2-FF synchronizer and then a stability counter. The accepted level changes after `DEBOUNCE_CYCLES` consecutive cycles of the new synchronized value. A rising accepted level produces exactly one pulse (`play_p`, `next_p`, `stop_p`). Releases produce no pulse. Bounces shorter than `DEBOUNCE_CYCLES` are discarded.
- **Target register** `tgt` (0 = source 1, 1 = source 2). Reset value is 0.
- **States:**
  - IDLE: `EN`=1, selects 00.
  - GAP: `EN`=1, selects 00; gap counter running.
  - PLAY: `EN`=0; the select for `tgt` is 1 and the other is 0.
- **Transitions.** Priority within a cycle is stop > next > play > done.
  - IDLE: `play_p` → GAP, gap counter = 0, `tgt` unchanged. `next_p` toggles `tgt` and stays in IDLE.
  - GAP: `stop_p` → IDLE. `next_p` toggles `tgt` and restarts the counter at 0. When the counter reaches `GAP_CYCLES-1` → PLAY.
  - PLAY: `stop_p` → IDLE. `next_p` toggles `tgt` → GAP. A `done` pulse matching `tgt` → GAP, and `tgt` toggles only if `loop_mode`=0. A `done` pulse from the non-selected source is ignored. `play_p` is ignored.
- **Restart pulse.** `start1`/`start2` pulse for one cycle, on the first cycle of PLAY, for the current `tgt` only.
- **Mux invariants.**
  - `sakura` and `badapple` are never both 1.
  - In all states other than PLAY they are both 0 and `EN`=1. This keeps the mux in its defined blank branch.
- **Reset.** `rst` at any time, including mid-gap or mid-track, forces IDLE immediately.
  - `EN`=1; `sakura`, `badapple`, `start1`, `start2`, `playing` = 0; `tgt`=0.
  - Debounce state and gap counter clear.

## Timing
- All outputs are registered and change on the same edge as the state register, with no combinational path from inputs.
- **Key latency.** A clean press first sampled high at edge N produces its pulse at edge N+`DEBOUNCE_CYCLES`+3. A state change takes effect one further edge later.
- **Gap length.** From the edge entering GAP to the edge entering PLAY is exactly `GAP_CYCLES` cycles. `EN` falls on the PLAY entry edge, together with the select and start pulse.
- **Done latency.** A `done` pulse at edge N gives GAP (`EN`=1, selects 00) at edge N+1.
- **Simultaneous events.**
  - `done` coinciding with `next_p` toggles `tgt` once, not twice.
  - `stop_p` overrides everything in the same cycle.

## Structure
- Shared package/header: state encodings (`ST_IDLE`=2'd0, `ST_GAP`=2'd1, `ST_PLAY`=2'd2) and source indices (`SRC_SAKURA`=0, `SRC_BADAPPLE`=1).
- One sub-module, `key_debounce` (synchronizer, counter and rising-edge pulse, parameter `DEBOUNCE_CYCLES`), instantiated three times.
- FSM, target register and gap counter live in `play_scheduler` itself.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `GAP_CYCLES`=8.
- **Reset.** Assert `rst` mid-PLAY → same cycle `EN`=1 and `sakura`=`badapple`=0. After release the block stays in IDLE with `tgt`=0.
- **Play from idle.** Press play from IDLE (clean, 20 cycles) → pulse 7 edges after the first high sample. GAP is entered, then `EN`=0, `sakura`=1 and `start1`=1 for one cycle, exactly 8 cycles later.
- **End of track.** `done1` in PLAY with `loop_mode`=0 → next edge GAP. After 8 cycles `badapple`=1 and `start2` pulses. Repeat with `loop_mode`=1 → `sakura`=1 and `start1` pulses again.
- **Bounce rejection.** Play key toggling every 2 cycles for 30 cycles → no pulse and no state change. A wrong-source `done2` while playing source 1 → ignored.
- **Simultaneous events.** `next` press in GAP at counter 5 → `tgt` toggles and PLAY occurs 8 cycles after the press takes effect. `stop_p` coinciding with `done1` → IDLE, no GAP.
- **Select invariant.** A random press/done stream over 10k cycles → `sakura`&`badapple` never both 1, and `EN`=0 only when exactly one select is 1.

Source files
------------

// File: rtl/play_scheduler_pkg.sv
// Shared encodings for the play scheduler: FSM states and source indices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package play_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    // Target register value to source mapping
    localparam logic SRC_SAKURA   = 1'b0;
    localparam logic SRC_BADAPPLE = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// Key debounce: 2-FF synchronizer, stability counter, one-cycle press pulse.
// Latency: a clean press first sampled at edge N pulses at edge N+DEBOUNCE_CYCLES+3.
// Backpressure: none; releases and short bounces produce no pulse.
//
// Ports:
//   clk, rst  - system clock, async active-high reset
//   key       - raw asynchronous key level (active high)
//   press     - registered one-cycle pulse on an accepted rising level
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= key;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            // cnt counts edges on which the synchronized key has disagreed with
            // the accepted level; the level flips once the disagreement has
            // persisted through the whole window and still holds.
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/play_scheduler.sv
// Sequencer for the two-source VGA/audio mux: keys, blanked gap, auto-advance/loop.
// Latency: all outputs registered; done -> GAP in one edge, GAP -> PLAY in GAP_CYCLES.
// Backpressure: none; key pulses and done pulses are acted on the cycle they arrive.
//
// Ports:
//   clk, rst                    - system clock, async active-high reset
//   btn_play/btn_next/btn_stop  - raw front-panel keys
//   loop_mode                   - 1 replays the current track on end-of-track
//   done1/done2                 - end-of-track pulses from sakura/badapple players
//   EN                          - mux blank/mute (1 = black and silent)
//   sakura/badapple             - source selects, only ever set in PLAY
//   start1/start2               - restart pulse on the first PLAY cycle
//   playing                     - high in PLAY
module play_scheduler
    import play_scheduler_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned GAP_CYCLES      = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_play,
    input  logic btn_next,
    input  logic btn_stop,
    input  logic loop_mode,
    input  logic done1,
    input  logic done2,
    output logic EN,
    output logic sakura,
    output logic badapple,
    output logic start1,
    output logic start2,
    output logic playing
);

    localparam int GW = $clog2(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic play_p;
    logic next_p;
    logic stop_p;

    state_t        state_q, state_n;
    logic          tgt_q, tgt_n;
    logic [GW-1:0] gcnt_q, gcnt_n;
    logic          done_sel;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_play (
        .clk   (clk),
        .rst   (rst),
        .key   (btn_play),
        .press (play_p)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk   (clk),
        .rst   (rst),
        .key   (btn_next),
        .press (next_p)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
        .clk   (clk),
        .rst   (rst),
        .key   (btn_stop),
        .press (stop_p)
    );

    // Only the end-of-track from the source on air counts
    assign done_sel = (tgt_q == SRC_SAKURA) ? done1 : done2;

    // Priority is stop > next > play > done in every state
    always_comb begin
        state_n = state_q;
        tgt_n   = tgt_q;
        gcnt_n  = gcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (stop_p) begin
                    state_n = ST_IDLE;
                end else if (next_p) begin
                    tgt_n = ~tgt_q;
                end else if (play_p) begin
                    state_n = ST_GAP;
                    gcnt_n  = '0;
                end
            end
            ST_GAP: begin
                if (stop_p) begin
                    state_n = ST_IDLE;
                end else if (next_p) begin
                    tgt_n  = ~tgt_q;
                    gcnt_n = '0;
                end else if (gcnt_q == GAP_LAST) begin
                    state_n = ST_PLAY;
                end else begin
                    gcnt_n = gcnt_q + 1'b1;
                end
            end
            ST_PLAY: begin
                if (stop_p) begin
                    state_n = ST_IDLE;
                end else if (next_p) begin
                    tgt_n   = ~tgt_q;
                    state_n = ST_GAP;
                    gcnt_n  = '0;
                end else if (done_sel) begin
                    // play_p is ignored here, so it cannot mask a done
                    state_n = ST_GAP;
                    gcnt_n  = '0;
                    if (!loop_mode) begin
                        tgt_n = ~tgt_q;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they switch on the same
    // edge as the state register with no input-to-output path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            tgt_q    <= SRC_SAKURA;
            gcnt_q   <= '0;
            EN       <= 1'b1;
            sakura   <= 1'b0;
            badapple <= 1'b0;
            start1   <= 1'b0;
            start2   <= 1'b0;
            playing  <= 1'b0;
        end else begin
            state_q  <= state_n;
            tgt_q    <= tgt_n;
            gcnt_q   <= gcnt_n;
            EN       <= (state_n != ST_PLAY);
            sakura   <= (state_n == ST_PLAY) && (tgt_n == SRC_SAKURA);
            badapple <= (state_n == ST_PLAY) && (tgt_n == SRC_BADAPPLE);
            start1   <= (state_n == ST_PLAY) && (state_q != ST_PLAY) && (tgt_n == SRC_SAKURA);
            start2   <= (state_n == ST_PLAY) && (state_q != ST_PLAY) && (tgt_n == SRC_BADAPPLE);
            playing  <= (state_n == ST_PLAY);
        end
    end

endmodule
